// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: the state encoding, the instruction register width,
// the opcodes and the IR capture pattern.
package jtag_tap_pkg;

  localparam int unsigned IR_W = 4;

  typedef enum logic [3:0] {
    ST_TLR   = 4'h0,
    ST_RTI   = 4'h1,
    ST_SELDR = 4'h2,
    ST_CAPDR = 4'h3,
    ST_SHDR  = 4'h4,
    ST_EX1DR = 4'h5,
    ST_PDR   = 4'h6,
    ST_EX2DR = 4'h7,
    ST_UPDR  = 4'h8,
    ST_SELIR = 4'h9,
    ST_CAPIR = 4'hA,
    ST_SHIR  = 4'hB,
    ST_EX1IR = 4'hC,
    ST_PIR   = 4'hD,
    ST_EX2IR = 4'hE,
    ST_UPIR  = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] IR_EXTEST         = 4'b0000;
  localparam logic [IR_W-1:0] IR_SAMPLE_PRELOAD = 4'b0001;
  localparam logic [IR_W-1:0] IR_IDCODE         = 4'b0010;
  localparam logic [IR_W-1:0] IR_USERCODE       = 4'b0011;
  localparam logic [IR_W-1:0] IR_DEBUG          = 4'b1000;
  localparam logic [IR_W-1:0] IR_BYPASS         = 4'b1111;

  localparam logic [IR_W-1:0] IR_CAPTURE        = 4'b0101;

endpackage

// File: rtl/universal_jtag_tap_core.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, 4-bit IR, IDCODE/USERCODE/BYPASS
// data registers and an external DEBUG chain whose serial output is muxed onto TDO.
module universal_jtag_tap_core
  import jtag_tap_pkg::*;
#(
  parameter              TECHNOLOGY    = "Generic",
  parameter logic [31:0] JTAG_IDCODE   = 32'h0000_0DDD,
  parameter logic [31:0] JTAG_USERCODE = 32'h0000_0000
) (
  input  logic jtag_tck,
  input  logic jtag_trstn,
  input  logic power_on_resetn,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  output logic jtag_tdo_oe,
  output logic tap_tck,
  output logic tap_TestLogicReset,
  output logic tap_CaptureDR,
  output logic tap_ShiftDR,
  output logic tap_PauseDR,
  output logic tap_UpdateDR,
  output logic dbg_sel,
  output logic dbg_tdi,
  input  logic dbg_tdo
);

  logic            rst_n;
  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]     idcode_sr_q, idcode_sr_d;
  logic [31:0]     usercode_sr_q, usercode_sr_d;
  logic            bypass_q, bypass_d;
  logic            tdo_q, tdo_d;
  logic            tdo_oe_q, tdo_oe_d;

  assign rst_n = jtag_trstn & power_on_resetn;

  // Only the generic cell exists; any other selection falls back to a pass-through.
  if (TECHNOLOGY == "Generic") begin : g_tck_generic
    assign tap_tck = jtag_tck;
  end else begin : g_tck_fallback
    assign tap_tck = jtag_tck;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:   state_d = jtag_tms ? ST_TLR   : ST_RTI;
      ST_RTI:   state_d = jtag_tms ? ST_SELDR : ST_RTI;
      ST_SELDR: state_d = jtag_tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = jtag_tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = jtag_tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = jtag_tms ? ST_UPDR  : ST_PDR;
      ST_PDR:   state_d = jtag_tms ? ST_EX2DR : ST_PDR;
      ST_EX2DR: state_d = jtag_tms ? ST_UPDR  : ST_SHDR;
      ST_UPDR:  state_d = jtag_tms ? ST_SELDR : ST_RTI;
      ST_SELIR: state_d = jtag_tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = jtag_tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = jtag_tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = jtag_tms ? ST_UPIR  : ST_PIR;
      ST_PIR:   state_d = jtag_tms ? ST_EX2IR : ST_PIR;
      ST_EX2IR: state_d = jtag_tms ? ST_UPIR  : ST_SHIR;
      ST_UPIR:  state_d = jtag_tms ? ST_SELDR : ST_RTI;
      default:  state_d = ST_TLR;
    endcase
  end

  always_comb begin
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    idcode_sr_d   = idcode_sr_q;
    usercode_sr_d = usercode_sr_q;
    bypass_d      = bypass_q;
    case (state_q)
      ST_TLR:   ir_d    = IR_IDCODE;
      ST_CAPIR: ir_sr_d = IR_CAPTURE;
      ST_SHIR:  ir_sr_d = {jtag_tdi, ir_sr_q[IR_W-1:1]};
      ST_UPIR:  ir_d    = ir_sr_q;
      ST_CAPDR: begin
        idcode_sr_d   = JTAG_IDCODE;
        usercode_sr_d = JTAG_USERCODE;
        bypass_d      = 1'b0;
      end
      ST_SHDR: begin
        case (ir_q)
          IR_IDCODE:   idcode_sr_d   = {jtag_tdi, idcode_sr_q[31:1]};
          IR_USERCODE: usercode_sr_d = {jtag_tdi, usercode_sr_q[31:1]};
          IR_DEBUG:    ;
          default:     bypass_d      = jtag_tdi;
        endcase
      end
      default: ;
    endcase
  end

  // TDO holds its last value outside the shift states.
  always_comb begin
    tdo_d    = tdo_q;
    tdo_oe_d = (state_q == ST_SHIR) || (state_q == ST_SHDR);
    if (state_q == ST_SHIR) begin
      tdo_d = ir_sr_q[0];
    end else if (state_q == ST_SHDR) begin
      case (ir_q)
        IR_IDCODE:   tdo_d = idcode_sr_q[0];
        IR_USERCODE: tdo_d = usercode_sr_q[0];
        IR_DEBUG:    tdo_d = dbg_tdo;
        default:     tdo_d = bypass_q;
      endcase
    end
  end

  always_ff @(posedge jtag_tck) begin
    if (!rst_n) begin
      state_q       <= ST_TLR;
      ir_q          <= IR_IDCODE;
      ir_sr_q       <= '0;
      idcode_sr_q   <= '0;
      usercode_sr_q <= '0;
      bypass_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      idcode_sr_q   <= idcode_sr_d;
      usercode_sr_q <= usercode_sr_d;
      bypass_q      <= bypass_d;
    end
  end

  always_ff @(negedge jtag_tck) begin
    if (!rst_n) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign jtag_tdo           = tdo_q;
  assign jtag_tdo_oe        = tdo_oe_q;
  assign tap_TestLogicReset = (state_q == ST_TLR);
  assign tap_CaptureDR      = (state_q == ST_CAPDR);
  assign tap_ShiftDR        = (state_q == ST_SHDR);
  assign tap_PauseDR        = (state_q == ST_PDR);
  assign tap_UpdateDR       = (state_q == ST_UPDR);
  assign dbg_sel            = (ir_q == IR_DEBUG);
  assign dbg_tdi            = jtag_tdi;

endmodule

// File: tb/tb_universal_jtag_tap_core.sv
// Scoreboard bench: a table-driven TAP model predicts TDO bits into a queue that a
// falling-edge monitor drains whenever the core drives TDO.
module tb_universal_jtag_tap_core;

  localparam logic [31:0] TB_IDCODE   = 32'h0000_0DDD;
  localparam logic [31:0] TB_USERCODE = 32'hA5A5_0001;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11,
                 EX1IR = 12, PIR = 13, EX2IR = 14, UPIR = 15;

  // Next state for TMS=1 and TMS=0, indexed by current state.
  int nxt1[16] = '{TLR, SELDR, SELIR, EX1DR, EX1DR, UPDR, EX2DR, UPDR,
                   SELDR, TLR, EX1IR, EX1IR, UPIR, EX2IR, UPIR, SELDR};
  int nxt0[16] = '{RTI, RTI, CAPDR, SHDR, SHDR, PDR, PDR, SHDR,
                   RTI, CAPIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};

  logic jtag_tck = 1'b0;
  logic jtag_trstn = 1'b0;
  logic power_on_resetn = 1'b1;
  logic jtag_tms = 1'b1;
  logic jtag_tdi = 1'b0;
  logic dbg_tdo = 1'b0;
  logic jtag_tdo, jtag_tdo_oe, tap_tck;
  logic tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR;
  logic dbg_sel, dbg_tdi;

  universal_jtag_tap_core #(
    .JTAG_IDCODE  (TB_IDCODE),
    .JTAG_USERCODE(TB_USERCODE)
  ) dut (
    .jtag_tck          (jtag_tck),
    .jtag_trstn        (jtag_trstn),
    .power_on_resetn   (power_on_resetn),
    .jtag_tms          (jtag_tms),
    .jtag_tdi          (jtag_tdi),
    .jtag_tdo          (jtag_tdo),
    .jtag_tdo_oe       (jtag_tdo_oe),
    .tap_tck           (tap_tck),
    .tap_TestLogicReset(tap_TestLogicReset),
    .tap_CaptureDR     (tap_CaptureDR),
    .tap_ShiftDR       (tap_ShiftDR),
    .tap_PauseDR       (tap_PauseDR),
    .tap_UpdateDR      (tap_UpdateDR),
    .dbg_sel           (dbg_sel),
    .dbg_tdi           (dbg_tdi),
    .dbg_tdo           (dbg_tdo)
  );

  always #5 jtag_tck = ~jtag_tck;

  int n_checks = 0;
  int n_pass = 0;
  int n_exp_shift = 0;
  int n_oe_seen = 0;
  bit exp_q[$];

  int         m_state = TLR;
  logic [3:0] m_ir = 4'b0010;
  bit         m_q[$];
  bit         m_valid = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic logic [4:0] decode_vec(int s);
    return {s == TLR, s == CAPDR, s == SHDR, s == PDR, s == UPDR};
  endfunction

  // One TCK cycle: check and predict for the current state, then drive the inputs
  // that the next rising edge will sample and advance the model accordingly.
  task automatic step(input logic tms, input logic tdi, input bit rst);
    logic       dtdo;
    logic [3:0] v;
    @(posedge jtag_tck);
    #2;
    dtdo = 1'($urandom_range(1));
    if (m_valid) begin
      chk("state_decodes",
          {27'd0, tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR},
          {27'd0, decode_vec(m_state)});
      chk("dbg_sel", {31'd0, dbg_sel}, {31'd0, m_ir == 4'b1000});
    end
    if (m_valid && !rst && (m_state == SHDR || m_state == SHIR)) begin
      if (m_state == SHDR && m_ir == 4'b1000) exp_q.push_back(dtdo);
      else exp_q.push_back(m_q[0]);
      n_exp_shift++;
    end
    dbg_tdo  = dtdo;
    jtag_tms = tms;
    jtag_tdi = tdi;
    if (rst) begin
      if ($urandom_range(1) == 1) jtag_trstn = 1'b0;
      else power_on_resetn = 1'b0;
    end else begin
      jtag_trstn = 1'b1;
      power_on_resetn = 1'b1;
    end
    if (rst) begin
      m_state = TLR;
      m_ir    = 4'b0010;
      m_q.delete();
      m_valid = 1;
    end else begin
      case (m_state)
        TLR:   m_ir = 4'b0010;
        CAPIR: begin
          m_q.delete();
          v = 4'b0101;
          for (int i = 0; i < 4; i++) m_q.push_back(v[i]);
        end
        SHIR: begin
          m_q.push_back(tdi);
          void'(m_q.pop_front());
        end
        UPIR: begin
          for (int i = 0; i < 4; i++) v[i] = m_q[i];
          m_ir = v;
        end
        CAPDR: begin
          m_q.delete();
          if (m_ir == 4'b0010) for (int i = 0; i < 32; i++) m_q.push_back(TB_IDCODE[i]);
          else if (m_ir == 4'b0011) for (int i = 0; i < 32; i++) m_q.push_back(TB_USERCODE[i]);
          else if (m_ir != 4'b1000) m_q.push_back(1'b0);
        end
        SHDR: begin
          if (m_ir != 4'b1000) begin
            m_q.push_back(tdi);
            void'(m_q.pop_front());
          end
        end
        default: ;
      endcase
      m_state = tms ? nxt1[m_state] : nxt0[m_state];
    end
    #1;
    chk("dbg_tdi", {31'd0, dbg_tdi}, {31'd0, tdi});
  endtask

  task automatic goto_rti();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  // From RTI: load the IR and return to RTI.
  task automatic scan_ir(input logic [3:0] val);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, val[i], 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  // From RTI: shift n DR bits of the given pattern (random beyond 32) and return to RTI.
  task automatic scan_dr(input int n, input logic [31:0] pat);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < n; i++)
      step(i == n - 1, (i < 32) ? pat[i] : 1'($urandom_range(1)), 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge jtag_tck);
      #2;
      if (jtag_tdo_oe === 1'b1) begin
        n_oe_seen++;
        if (exp_q.size() == 0) chk("tdo_unexpected_oe", {31'd0, jtag_tdo_oe}, 32'd0);
        else chk("tdo_bit", {31'd0, jtag_tdo}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : stimulus
    logic [3:0] ops[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1111};
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1);
    chk("reset_tdo", {31'd0, jtag_tdo}, 32'd0);
    chk("reset_tdo_oe", {31'd0, jtag_tdo_oe}, 32'd0);
    chk("reset_tlr", {31'd0, tap_TestLogicReset}, 32'd1);
    chk("reset_dbg_sel", {31'd0, dbg_sel}, 32'd0);

    // IDCODE straight out of reset: TMS 0,1,0,0 then 32 shifts.
    step(1'b0, 1'b0, 0);
    scan_dr(32, $urandom);
    scan_ir(4'b1111);
    scan_dr(4, 32'b1101);
    scan_ir(4'b1010);
    scan_ir(4'b1000);
    scan_dr(12, $urandom);
    scan_ir(4'b0011);
    scan_dr(32, $urandom);

    // Five TMS=1 edges from SHDR, then a DR scan that must see IDCODE again.
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    scan_dr(32, $urandom);

    // Reset in the middle of a DEBUG DR shift and of an IR shift.
    scan_ir(4'b1000);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(1)), 0);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 0);
    scan_dr(32, $urandom);

    // Randomised scans mixing opcodes, lengths and pauses.
    for (int r = 0; r < 20; r++) begin
      goto_rti();
      if ($urandom_range(3) == 0) scan_ir(4'($urandom));
      else scan_ir(ops[$urandom_range(5)]);
      scan_dr($urandom_range(40, 1), $urandom);
    end

    // Free-running random walk with occasional resets.
    for (int r = 0; r < 400; r++)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(63) == 0);

    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0);
    #20;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("oe_cycle_count", n_oe_seen, n_exp_shift);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
